synapse_mac: RTL and testbench

//  Upstream feeder for the neuron body. Latches an input spike vector and serially

---
 rtl/synapse_mac.sv | 153 +++++++++++++++
 tb/tb_synapse_mac.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/synapse_mac.sv
// synapse_mac: latches a spike vector and serially accumulates the weights of the
// inputs that fired, one input per clock. The sum is clamped to SAT_MAX on output
// and announced with a single-cycle out_valid pulse. Weights live in a local
// register file that can be written in any state.
module synapse_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int SAT_MAX    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_we,
  input  logic [IDX_WIDTH-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  in_start,
  input  logic [NUM_IN-1:0]     in_spikes,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_mac_sum
);

  // Accumulator is wide enough for NUM_IN full-scale weights, so it never wraps.
  localparam int ACC_W = DATA_WIDTH + IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_IN - 1);
  localparam logic [ACC_W-1:0]      SAT_ACC  = ACC_W'(SAT_MAX);
  localparam logic [DATA_WIDTH-1:0] SAT_OUT  = DATA_WIDTH'(SAT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [NUM_IN-1:0]     spk_q, spk_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] w_q [NUM_IN];

  logic [DATA_WIDTH-1:0] w_rd;
  logic [NUM_IN-1:0]     spk_sh;
  logic                  spk_bit;

  // Output clamp; the accumulator itself is never saturated.
  function automatic logic [DATA_WIDTH-1:0] sat_fn(input logic [ACC_W-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    if (a > SAT_ACC) begin
      r = SAT_OUT;
    end else begin
      r = a[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Weight register file: cleared by reset, written whenever w_we is set.
  // Addresses at or above NUM_IN match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_we && (w_addr == IDX_WIDTH'(i))) begin
          w_q[i] <= w_data;
        end else begin
          w_q[i] <= w_q[i];
        end
      end
    end
  end

  // Select the weight and spike bit for the current index (pre-edge values, so a
  // write landing on the same edge is not seen by this read).
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_rd = w_rd | (w_q[i] & {DATA_WIDTH{idx_q == IDX_WIDTH'(i)}});
    end
    spk_sh  = spk_q >> idx_q;
    spk_bit = spk_sh[0];
  end

  // Next-state logic for the IDLE -> ACCUM -> DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    spk_d   = spk_q;
    valid_d = 1'b0;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          spk_d   = in_spikes;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (spk_bit) begin
          acc_d = acc_q + ACC_W'(w_rd);
        end else begin
          acc_d = acc_q;
        end
        idx_d = idx_q + IDX_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        sum_d   = sat_fn(acc_q);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequence registers and registered outputs; reset aborts any operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      spk_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      spk_q   <= spk_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = valid_q;
  assign out_mac_sum = sum_q;

endmodule

// File: tb/tb_synapse_mac.sv
// Bench for synapse_mac: two instances (default clamp 255 and clamp 100) share
// stimulus; expected sums come from a weight-array model summed with plain arithmetic.
module tb_synapse_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = 4'd0;
  logic [7:0]  w_data = 8'd0;
  logic        in_start = 1'b0;
  logic [15:0] in_spikes = 16'd0;
  logic        busy_a, valid_a, busy_b, valid_b;
  logic [7:0]  sum_a, sum_b;

  int vectors = 0;
  int miscompares = 0;
  int w_m [16];

  synapse_mac dut_a (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_start(in_start), .in_spikes(in_spikes),
    .busy(busy_a), .out_valid(valid_a), .out_mac_sum(sum_a)
  );

  synapse_mac #(.SAT_MAX(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_start(in_start), .in_spikes(in_spikes),
    .busy(busy_b), .out_valid(valid_b), .out_mac_sum(sum_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sum(input logic [15:0] s);
    int t = 0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) t += w_m[i];
    end
    return t;
  endfunction

  function automatic int clampv(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic wr(input int a, input int d);
    w_we = 1'b1; w_addr = a[3:0]; w_data = d[7:0];
    tick();
    w_we = 1'b0;
    w_m[a] = d;
  endtask

  task automatic start(input logic [15:0] s);
    in_spikes = s; in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  // Called right after the start edge; optionally drives one extra stimulus in cycle
  // inj_n (applied at edge inj_n+1). Returns the edge count of the first pulse.
  task automatic wait_pulse(input int inj_n, input logic inj_start, input logic [15:0] inj_spk,
                            input logic inj_we, input int inj_a, input int inj_d,
                            output int lat, output int bcnt);
    lat = -1;
    bcnt = busy_a ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      if (n - 1 == inj_n) begin
        in_start = inj_start; in_spikes = inj_spk;
        w_we = inj_we; w_addr = inj_a[3:0]; w_data = inj_d[7:0];
      end else begin
        in_start = 1'b0; w_we = 1'b0;
      end
      tick();
      if (valid_a) begin
        lat = n;
        break;
      end
      if (busy_a) bcnt++;
    end
    in_start = 1'b0; w_we = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input int lat, input int bcnt, input int exp);
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_busy_cycles"}, bcnt, 17);
    chk({tag, "_busy_at_pulse"}, busy_a, 0);
    chk({tag, "_sum255"}, sum_a, clampv(exp, 255));
    chk({tag, "_valid100"}, valid_b, 1);
    chk({tag, "_sum100"}, sum_b, clampv(exp, 100));
  endtask

  task automatic op(input string tag, input logic [15:0] s);
    int exp, lat, bcnt;
    exp = ref_sum(s);
    start(s);
    wait_pulse(-1, 1'b0, s, 1'b0, 0, 0, lat, bcnt);
    check_pulse(tag, lat, bcnt, exp);
    tick();
    chk({tag, "_pulse_one_cycle"}, valid_a, 0);
    chk({tag, "_sum_hold"}, sum_a, clampv(exp, 255));
  endtask

  task automatic count_pulses(input int ncyc, output int cnt);
    cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (valid_a || valid_b) cnt++;
    end
  endtask

  initial begin
    int lat, bcnt, exp, cnt;
    for (int i = 0; i < 16; i++) w_m[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_sum", sum_a, 0);
    chk("rst_sum100", sum_b, 0);
    rst_n = 1'b1;
    tick();

    // T1: ramp weights, inputs 0 and 2
    for (int i = 0; i < 16; i++) wr(i, i + 1);
    op("t1", 16'h0005);

    // T2: saturation at both clamp values
    for (int i = 0; i < 16; i++) wr(i, 20);
    op("t2", 16'hFFFF);

    // T3: no spikes still runs the full sequence
    op("t3", 16'h0000);

    // T4: start during ACCUM ignored; start in pulse cycle accepted
    for (int i = 0; i < 16; i++) wr(i, i + 1);
    exp = ref_sum(16'h00F0);
    start(16'h00F0);
    wait_pulse(5, 1'b1, 16'h000F, 1'b0, 0, 0, lat, bcnt);
    check_pulse("t4_first", lat, bcnt, exp);
    exp = ref_sum(16'h8001);
    start(16'h8001);
    chk("t4_chain_valid_low", valid_a, 0);
    chk("t4_chain_busy", busy_a, 1);
    wait_pulse(-1, 1'b0, 16'h8001, 1'b0, 0, 0, lat, bcnt);
    check_pulse("t4_second", lat, bcnt, exp);
    count_pulses(30, cnt);
    chk("t4_no_extra_pulse", cnt, 0);

    // T5: mid-operation weight writes
    wr(3, 1);
    start(16'h0009);
    wait_pulse(1, 1'b0, 16'h0009, 1'b1, 3, 50, lat, bcnt);
    w_m[3] = 50;
    check_pulse("t5_early_write", lat, bcnt, ref_sum(16'h0009));
    exp = ref_sum(16'h0003);
    start(16'h0003);
    wait_pulse(0, 1'b0, 16'h0003, 1'b1, 0, 50, lat, bcnt);
    w_m[0] = 50;
    check_pulse("t5_same_edge_write", lat, bcnt, exp);
    op("t5_write_landed", 16'h0001);

    // Randomized weights and spike vectors
    for (int k = 0; k < 20; k++) begin
      int nw;
      logic [15:0] s;
      nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++) wr($urandom_range(0, 15), $urandom_range(0, 255));
      s = 16'($urandom);
      op("rnd", s);
    end

    // T6: reset in the middle of ACCUM
    for (int i = 0; i < 16; i++) wr(i, 30);
    op("t6_pre", 16'hFFFF);
    start(16'hFFFF);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy_a, 0);
    chk("t6_valid", valid_a, 0);
    chk("t6_sum", sum_a, 0);
    chk("t6_sum100", sum_b, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) w_m[i] = 0;
    count_pulses(30, cnt);
    chk("t6_no_pulse_after_reset", cnt, 0);
    op("t6_weights_cleared", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
